// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants and state type for the frame readout path
package frame_pkg;

   localparam int FRAME_WIDTH         = 320;
   localparam int FRAME_HEIGHT        = 256;
   localparam int PIXELS_PER_WORD     = 2;
   localparam int FRAME_WORDS_DEFAULT = FRAME_WIDTH * FRAME_HEIGHT / PIXELS_PER_WORD;

   typedef enum logic [1:0] {
      FRD_IDLE  = 2'd0,
      FRD_REQ   = 2'd1,
      FRD_DATA  = 2'd2,
      FRD_DRAIN = 2'd3
   } frd_state_t;

endpackage

// File: rtl/frame_word_fifo.sv
// rtl/frame_word_fifo.sv - show-ahead word FIFO with occupancy count
module frame_word_fifo #(
   parameter int  DEPTH = 16,
   parameter int  WIDTH = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Storage is not reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/frame_readout.sv
// rtl/frame_readout.sv - bursts a stored frame out of HyperRAM as a 16-bit pixel stream
module frame_readout
   import frame_pkg::*;
#(
   parameter int          FRAME_WORDS = FRAME_WORDS_DEFAULT,
   parameter int          BURST_LEN   = 8,
   parameter logic [31:0] BASE_ADDR   = 32'd0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic        rd_ack,
   input  logic        rd_valid,
   input  logic [31:0] rd_d,
   output logic [15:0] output_d,
   output logic        output_rdy,
   input  logic        output_next,
   output logic        output_error
);

   localparam int DEPTH = 2 * BURST_LEN;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int BW    = $clog2(BURST_LEN);
   localparam int WCW   = $clog2(FRAME_WORDS + 1);

   if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_frame_words
      $error("FRAME_WORDS must be a multiple of BURST_LEN");
   end

   frd_state_t       state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [WCW-1:0]   words_q, words_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic             err_q, err_d;
   logic [31:0]      hold_q, hold_d;
   logic             half_q, half_d;
   logic             hold_vld_q, hold_vld_d;

   logic             fifo_wr;
   logic             fifo_rd;
   logic [31:0]      fifo_rd_data;
   logic [CW-1:0]    fifo_count;
   logic [CW-1:0]    fifo_free;
   logic             fifo_full;
   logic             fifo_empty;

   frame_word_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (fifo_wr),
      .wr_data (rd_d),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // A burst is only requested when the whole burst is guaranteed to fit.
   assign fifo_free    = CW'(DEPTH) - fifo_count;
   assign rd_req       = (state_q == FRD_REQ) && (fifo_free >= CW'(BURST_LEN));
   assign rd_addr      = addr_q;
   assign busy         = (state_q != FRD_IDLE);
   assign output_rdy   = hold_vld_q;
   assign output_d     = half_q ? hold_q[15:0] : hold_q[31:16];
   assign output_error = err_q;

   // Burst sequencing: request, collect beats, advance address, drain at end of frame.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      words_d = words_q;
      beat_d  = beat_q;
      err_d   = err_q;
      fifo_wr = 1'b0;
      done    = 1'b0;
      case (state_q)
         FRD_IDLE: begin
            if (start) begin
               words_d = '0;
               beat_d  = '0;
               err_d   = 1'b0;
               addr_d  = BASE_ADDR;
               state_d = FRD_REQ;
            end
         end
         FRD_REQ: begin
            if (rd_req && rd_ack) begin
               words_d = words_q + WCW'(BURST_LEN);
               beat_d  = '0;
               state_d = FRD_DATA;
            end
         end
         FRD_DATA: begin
            if (rd_valid) begin
               // An overflowing beat is dropped but still counts toward the burst.
               if (fifo_full) err_d = 1'b1;
               else           fifo_wr = 1'b1;
               beat_d = beat_q + BW'(1);
               if (beat_q == BW'(BURST_LEN - 1)) begin
                  addr_d  = addr_q + 32'(BURST_LEN);
                  state_d = (words_q == WCW'(FRAME_WORDS)) ? FRD_DRAIN : FRD_REQ;
               end
            end
         end
         FRD_DRAIN: begin
            if (fifo_empty && !hold_vld_q) begin
               done    = 1'b1;
               state_d = FRD_IDLE;
            end
         end
         default: state_d = FRD_IDLE;
      endcase
      // Beats outside a burst are discarded and flagged.
      if (rd_valid && (state_q != FRD_DATA)) err_d = 1'b1;
   end

   // Unpacker: upper half first, reload straight from the FIFO on the lower half so words chain without a bubble.
   always_comb begin
      hold_d     = hold_q;
      half_d     = half_q;
      hold_vld_d = hold_vld_q;
      fifo_rd    = 1'b0;
      if (!hold_vld_q) begin
         fifo_rd = !fifo_empty;
      end else if (output_next) begin
         if (!half_q)          half_d = 1'b1;
         else if (!fifo_empty) fifo_rd = 1'b1;
         else                  hold_vld_d = 1'b0;
      end
      if (fifo_rd) begin
         hold_d     = fifo_rd_data;
         half_d     = 1'b0;
         hold_vld_d = 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= FRD_IDLE;
         addr_q  <= BASE_ADDR;
         words_q <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         words_q <= words_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   // Unpacker holding register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hold_q     <= '0;
         half_q     <= 1'b0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         half_q     <= half_d;
         hold_vld_q <= hold_vld_d;
      end
   end

endmodule

// File: tb/tb_frame_readout.sv
// tb/tb_frame_readout.sv - scoreboard bench for frame_readout with a HyperRAM controller model
module tb_frame_readout;

   localparam int          FW    = 32;
   localparam int          BL    = 8;
   localparam int          DEPTH = 2 * BL;
   localparam logic [31:0] BASE  = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, rd_req;
   logic [31:0] rd_addr;
   logic        rd_ack = 1'b0;
   logic        rd_valid = 1'b0;
   logic [31:0] rd_d = '0;
   logic [15:0] output_d;
   logic        output_rdy;
   logic        output_next = 1'b0;
   logic        output_error;

   frame_readout #(
      .FRAME_WORDS (FW),
      .BURST_LEN   (BL),
      .BASE_ADDR   (BASE)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_ack       (rd_ack),
      .rd_valid     (rd_valid),
      .rd_d         (rd_d),
      .output_d     (output_d),
      .output_rdy   (output_rdy),
      .output_next  (output_next),
      .output_error (output_error)
   );

   always #5 clk = ~clk;

   int          ntests = 0;
   int          nfail = 0;
   int          cyc = 0;
   int          ack_max = 0;
   int          gap_max = 0;
   int          cons_mode = 0;
   logic [31:0] seed = '0;
   logic [15:0] exp_q[$];
   logic [31:0] addr_exp_q[$];
   int          pop_idx = 0;
   int          addr_idx = 0;
   int          pop_cyc[int];
   int          last_pop_cyc = -10;
   int          done_cnt = 0;
   int          spur_req = 0;
   int          spur_done = 0;
   int          cmode = 0;
   int          ack_cnt = 0;
   int          gap_cnt = 0;
   int          beat_i = 0;
   logic [31:0] cur_addr = '0;
   int          delivered = 0;
   int          consumed = 0;

   // Memory contents: word at address a = {2a, 2a+1} xor a per-frame seed.
   function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
      logic [15:0] k2;
      k2 = {a[14:0], 1'b0};
      return {k2 ^ s[15:0], (k2 + 16'd1) ^ s[31:16]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Controller model plus consumer/monitor, all on the falling edge.
   always @(negedge clk) begin
      cyc++;
      rd_ack   = 1'b0;
      rd_valid = 1'b0;
      if (!resetn) begin
         cmode       = 0;
         addr_idx    = addr_exp_q.size();
         pop_idx     = exp_q.size();
         delivered   = 0;
         consumed    = 0;
         output_next = 1'b0;
         spur_done   = spur_req;
      end else begin
         case (cmode)
            0: begin
               if (spur_req != spur_done) begin
                  rd_valid = 1'b1;
                  rd_d     = 32'hDEAD_BEEF;
                  spur_done++;
               end else if (rd_req) begin
                  check("rd_req within frame", 32'(addr_idx < addr_exp_q.size()), 32'd1);
                  if (addr_idx < addr_exp_q.size()) begin
                     check("rd_addr", rd_addr, addr_exp_q[addr_idx]);
                     addr_idx++;
                  end
                  check("free space at rd_req",
                        32'((delivered - (consumed + 1) / 2) <= (DEPTH - BL + 1)), 32'd1);
                  cur_addr = rd_addr;
                  ack_cnt  = $urandom_range(ack_max, 0);
                  if (ack_cnt == 0) begin
                     rd_ack  = 1'b1;
                     cmode   = 2;
                     beat_i  = 0;
                     gap_cnt = $urandom_range(gap_max, 0);
                  end else begin
                     cmode = 1;
                  end
               end
            end
            1: begin
               check("rd_req held stable", 32'({rd_req, rd_addr == cur_addr}), 32'd3);
               ack_cnt--;
               if (ack_cnt == 0) begin
                  rd_ack  = 1'b1;
                  cmode   = 2;
                  beat_i  = 0;
                  gap_cnt = $urandom_range(gap_max, 0);
               end
            end
            default: begin
               if (gap_cnt > 0) begin
                  gap_cnt--;
               end else begin
                  rd_valid = 1'b1;
                  rd_d     = mem_word(cur_addr + 32'(beat_i), seed);
                  beat_i++;
                  delivered++;
                  gap_cnt = $urandom_range(gap_max, 0);
                  if (beat_i == BL) cmode = 0;
               end
            end
         endcase

         if (done) begin
            check("done one cycle after last pixel", 32'(cyc), 32'(last_pop_cyc + 1));
            check("done with all pixels consumed", 32'(pop_idx), 32'(exp_q.size()));
            done_cnt++;
         end

         case (cons_mode)
            0:       output_next = 1'b1;
            1:       output_next = ((cyc % 3) == 0);
            default: output_next = ($urandom_range(1, 0) == 1);
         endcase

         if (output_rdy && output_next) begin
            check("pixel within frame", 32'(pop_idx < exp_q.size()), 32'd1);
            if (pop_idx < exp_q.size()) begin
               check("pixel", 32'(output_d), 32'(exp_q[pop_idx]));
               pop_cyc[pop_idx] = cyc;
               pop_idx++;
               consumed++;
               if (pop_idx == exp_q.size()) last_pop_cyc = cyc;
            end
         end
      end
   end

   task automatic push_frame(output int base);
      logic [31:0] w;
      base = exp_q.size();
      for (int i = 0; i < FW; i++) begin
         w = mem_word(BASE + 32'(i), seed);
         exp_q.push_back(w[31:16]);
         exp_q.push_back(w[15:0]);
      end
      for (int b = 0; b < FW / BL; b++) addr_exp_q.push_back(BASE + 32'(b * BL));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy after start", 32'(busy), 32'd1);
      check("rd_req cycle after start", 32'(rd_req), 32'd1);
      check("error cleared by start", 32'(output_error), 32'd0);
   endtask

   task automatic run_frame(input int am, input int gm, input int cm,
                            input logic [31:0] sd, input bit mid_start, output int base);
      int d0;
      int n;
      @(negedge clk);
      ack_max   = am;
      gap_max   = gm;
      cons_mode = cm;
      seed      = sd;
      push_frame(base);
      d0 = done_cnt;
      pulse_start();
      if (mid_start) begin
         repeat (30) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (done_cnt < d0 + 1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("done within budget", 32'(done_cnt >= d0 + 1), 32'd1);
      repeat (5) @(negedge clk);
      check("single done pulse", 32'(done_cnt), 32'(d0 + 1));
      check("all pixels consumed", 32'(pop_idx), 32'(exp_q.size()));
      check("all bursts requested", 32'(addr_idx), 32'(addr_exp_q.size()));
      check("idle after done", 32'(busy), 32'd0);
      check("no error in frame", 32'(output_error), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " rd_req"}, 32'(rd_req), 32'd0);
      check({tag, " rd_addr"}, rd_addr, BASE);
      check({tag, " output_rdy"}, 32'(output_rdy), 32'd0);
      check({tag, " output_d"}, 32'(output_d), 32'd0);
      check({tag, " output_error"}, 32'(output_error), 32'd0);
   endtask

   initial begin
      int base;
      int n;
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      resetn = 1'b1;

      // Streaming consumer, immediate controller: pixels must come out back to back.
      run_frame(0, 0, 0, 32'd0, 1'b0, base);
      check("no bubble across frame",
            32'((pop_cyc.exists(base) && pop_cyc.exists(base + 2 * FW - 1))
                ? pop_cyc[base + 2 * FW - 1] - pop_cyc[base] : -1),
            32'(2 * FW - 1));

      // Backpressured consumer with controller jitter.
      run_frame(20, 3, 1, $urandom, 1'b0, base);
      run_frame(20, 4, 2, $urandom, 1'b0, base);

      // Spurious beat while idle.
      @(negedge clk);
      spur_req++;
      repeat (3) @(negedge clk);
      check("error after spurious beat", 32'(output_error), 32'd1);
      check("fifo empty after spurious beat", 32'(output_rdy), 32'd0);
      run_frame(5, 2, 2, $urandom, 1'b0, base);

      // start pulsed while busy is ignored.
      run_frame(8, 2, 1, $urandom, 1'b1, base);

      // Asynchronous reset in the middle of a burst.
      @(negedge clk);
      ack_max   = 3;
      gap_max   = 1;
      cons_mode = 1;
      seed      = $urandom;
      push_frame(base);
      pulse_start();
      n = 0;
      while (!(cmode == 2 && beat_i >= 3 && addr_idx >= 2) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reached second burst", 32'(n < 2000), 32'd1);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 check_reset_outputs("async reset");
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      run_frame(10, 3, 2, $urandom, 1'b0, base);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", ntests, nfail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/frame_readout.md
# frame_readout

Reads one captured Boson frame back out of HyperRAM and streams it as 16-bit pixels. It issues fixed-length burst reads to the RAM controller and buffers the returned 32-bit words in a small FIFO. It then unpacks each word into two pixels behind the same rdy/next handshake that `parallel_capture` presents. It sits between the HyperRAM controller's read port and the downstream consumer (SD writer / host link). It is the read-side counterpart of the capture path, which packs pixel pairs into words at consecutive word addresses.

## Interface
- `FRAME_WORDS`, 40960: 32-bit words per frame (320×256 pixels / 2); must be a multiple of `BURST_LEN`.
- `BURST_LEN`, 8: words per read burst; power of two, 2..64.
- `BASE_ADDR`, 0: word address of the frame's first word.
- `clk` in 1: system clock; all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a frame readout; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the last pixel has been consumed.
- `rd_req` out 1: burst read request; held until `rd_ack`.
- `rd_addr` out 32: word address of the burst; stable while `rd_req` is high.
- `rd_ack` in 1: controller accepts the request (one-cycle pulse).
- `rd_valid` in 1: one returned data beat.
- `rd_d` in 32: returned word.
- `output_d` out 16: current pixel.
- `output_rdy` out 1: `output_d` is valid.
- `output_next` in 1: consumer takes the current pixel; ignored while `output_rdy` is low.
- `output_error` out 1: sticky; beat arrived with FIFO full, or an extra beat arrived outside a burst.

## Operation
- Reset values: `busy`, `done`, `rd_req`, `output_rdy`, `output_error` = 0; `rd_addr` = `BASE_ADDR`; `output_d` = 0; FIFO empty; `state` = IDLE.
- State machine states: IDLE, REQ, DATA, DRAIN.
  - IDLE: on `start`, clear the word counter and `output_error`, set `rd_addr`=`BASE_ADDR`, and go to REQ.
  - REQ: assert `rd_req` once FIFO free space is ≥ `BURST_LEN`. On `rd_ack`, drop `rd_req` and go to DATA.
  - DATA: write each `rd_valid` beat to the FIFO and count beats. After `BURST_LEN` beats, `rd_addr` += `BURST_LEN`. If words requested == `FRAME_WORDS`, go to DRAIN; otherwise go to REQ.
  - DRAIN: once the FIFO and the holding register are empty, pulse `done`, clear `busy`, and go to IDLE.
- Unpacker: a 32-bit holding register plus a half bit.
  - Pixel order: `[31:16]` is output first, then `[15:0]`, matching capture packing.
  - On `output_next` with the upper half showing: switch to the lower half.
  - On `output_next` with the lower half showing: load the next FIFO word in the same cycle if one is available; otherwise drop `output_rdy`.
- `rd_valid` in IDLE, REQ or DRAIN: set `output_error` and discard the beat.
- `rd_valid` with FIFO full: set `output_error` and discard the beat; the beat is still counted.
- `start` while `busy`: no effect.
- Reset asserted mid-frame: all state is cleared immediately. The RAM controller must be reset with it.

## Timing
- `start` at cycle 0 → `rd_req` high at cycle 1.
- The earliest `rd_req` for the next burst is the cycle after the last beat of the current burst.
- FIFO write happens on the `rd_valid` edge.
- If the holding register is empty, the word is in the holding register and `output_rdy` is high one cycle after the FIFO write.
- Sustained throughput: one pixel per cycle while `output_next` is held high and the FIFO is non-empty, with no bubble at word boundaries.
- `done` follows the final `output_next` by exactly one cycle.
- Word counter width: $clog2(`FRAME_WORDS`+1). Address arithmetic is 32-bit, wrapping modulo 2^32.

## Structure
- Shared package `frame_pkg`:
  - `FRAME_WIDTH`=320, `FRAME_HEIGHT`=256, `PIXELS_PER_WORD`=2
  - state enum `frd_state_t`
- Sub-module `frame_word_fifo`: synchronous FIFO, 32 bits wide, depth 2×`BURST_LEN`, with `count` output for free-space checks, same `clk`/`resetn`.
- Elaboration-time check: `FRAME_WORDS` % `BURST_LEN` == 0.

## Test plan
- Single burst: `FRAME_WORDS`=8, memory word k = {16'(2k), 16'(2k+1)}, `output_next` held high → pixels 0..15 in order, then `done` one cycle after pixel 15; exactly one `rd_req` at address 0.
- Full frame with a backpressured consumer (`output_next` every 3rd cycle) → 81920 pixels in order. `rd_addr` steps 0, 8, 16, …, 40952. `rd_req` is never asserted with FIFO free space below 8. `output_error` stays 0.
- Controller latency jitter: `rd_ack` delayed 0–20 cycles, beats with random gaps → identical pixel stream; no bubble while the FIFO is non-empty.
- Spurious beat: `rd_valid` in IDLE → `output_error`=1, FIFO stays empty. The next `start` clears `output_error`.
- `start` pulsed mid-frame → ignored; the pixel count still equals 81920 and only one `done` pulse is seen.
- `resetn` low during DATA → all outputs return to reset values asynchronously. A following `start` reads from `BASE_ADDR` with correct data.
